// File: rtl/snake_dir_ctrl.sv
// Snake key controller: debounces direction/pause/speed keys, queues legal turns
// and emits the per-move enable/mode strobe at a selectable speed.
module snake_dir_ctrl #(
  parameter int unsigned TICK_BASE_CNT  = 27_000_000,
  parameter int unsigned DEBOUNCE_CNT   = 270_000,
  parameter bit          KEY_ACTIVE_LOW = 1'b1,
  parameter int unsigned DIR_FIFO_DEPTH = 2,
  parameter int unsigned SPEED_LEVELS   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [3:0]                      i_key_dir,
  input  logic                            i_key_pause,
  input  logic                            i_key_speed,
  output logic                            en,
  output logic [3:0]                      mode,
  output logic [1:0]                      forward,
  output logic                            paused,
  output logic [$clog2(SPEED_LEVELS)-1:0] speed_lvl,
  output logic                            led
);

  localparam int unsigned NKEYS     = 6;
  localparam int unsigned KEY_PAUSE = 4;
  localparam int unsigned KEY_SPEED = 5;
  localparam int unsigned DBW       = $clog2(DEBOUNCE_CNT + 1);
  localparam int unsigned PW        = (DIR_FIFO_DEPTH > 1) ? $clog2(DIR_FIFO_DEPTH) : 1;
  localparam int unsigned CW        = $clog2(DIR_FIFO_DEPTH + 1);
  localparam int unsigned LW        = $clog2(SPEED_LEVELS);
  localparam int unsigned TW        = 32;

  localparam logic [3:0] MODE_RESET  = 4'd0;
  localparam logic [3:0] MODE_UPDATE = 4'd1;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Key input path: polarity normalise, 2-FF sync, debounce, press events
  // ---------------------------------------------------------------------------
  logic [NKEYS-1:0]           key_raw_c;
  logic [NKEYS-1:0]           key_norm_c;
  logic [NKEYS-1:0]           sync1_q, sync2_q;
  logic [NKEYS-1:0]           deb_q, deb_d;
  logic [NKEYS-1:0]           evt_q, evt_d;
  logic [NKEYS-1:0][DBW-1:0]  db_cnt_q, db_cnt_d;

  assign key_raw_c  = {i_key_speed, i_key_pause, i_key_dir};
  assign key_norm_c = KEY_ACTIVE_LOW ? ~key_raw_c : key_raw_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      evt_q    <= '0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= key_norm_c;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      evt_q    <= evt_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // A level is accepted after DEBOUNCE_CNT consecutive cycles of disagreement
  always_comb begin
    deb_d    = deb_q;
    evt_d    = '0;
    db_cnt_d = db_cnt_q;
    for (int k = 0; k < NKEYS; k++) begin
      if (sync2_q[k] != deb_q[k]) begin
        if (db_cnt_q[k] == DBW'(DEBOUNCE_CNT - 1)) begin
          deb_d[k]    = sync2_q[k];
          evt_d[k]    = sync2_q[k];
          db_cnt_d[k] = '0;
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + DBW'(1);
        end
      end else begin
        db_cnt_d[k] = '0;
      end
    end
  end

  // Lowest-index direction event wins when several fire together
  logic       dir_evt_c;
  logic [1:0] dir_cand_c;

  always_comb begin
    dir_evt_c  = 1'b0;
    dir_cand_c = 2'b00;
    for (int i = 3; i >= 0; i--) begin
      if (evt_q[i]) begin
        dir_evt_c  = 1'b1;
        dir_cand_c = 2'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Move period per speed level, selected from elaboration-time constants
  // ---------------------------------------------------------------------------
  logic [LW-1:0] speed_q, speed_d;
  logic [TW-1:0] period_m1_c;

  always_comb begin
    period_m1_c = TW'(TICK_BASE_CNT - 1);
    for (int l = 0; l < SPEED_LEVELS; l++) begin
      if (speed_q == LW'(l)) begin
        period_m1_c = TW'((TICK_BASE_CNT >> l) - 1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Turn queue and move sequencing
  // ---------------------------------------------------------------------------
  state_e                           state_q, state_d;
  logic [TW-1:0]                    tick_cnt_q, tick_cnt_d;
  logic [1:0]                       fwd_q, fwd_d;
  logic                             en_q, en_d;
  logic [3:0]                       mode_q, mode_d;
  logic                             led_q, led_d;
  logic                             paused_q, paused_d;
  logic [DIR_FIFO_DEPTH-1:0][1:0]   fifo_q, fifo_d;
  logic [PW-1:0]                    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                    count_q, count_d;
  logic [PW-1:0]                    newest_idx_c;
  logic [1:0]                       ref_dir_c;
  logic                             tick_c, push_c, pop_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DIR_FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Turns are judged against the last queued turn, or the committed heading
  assign newest_idx_c = (wr_ptr_q == '0) ? PW'(DIR_FIFO_DEPTH - 1) : wr_ptr_q - PW'(1);
  assign ref_dir_c    = (count_q != '0) ? fifo_q[newest_idx_c] : fwd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_START;
      tick_cnt_q <= '0;
      speed_q    <= '0;
      fwd_q      <= 2'b00;
      en_q       <= 1'b0;
      mode_q     <= MODE_RESET;
      led_q      <= 1'b0;
      paused_q   <= 1'b0;
      fifo_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      speed_q    <= speed_d;
      fwd_q      <= fwd_d;
      en_q       <= en_d;
      mode_q     <= mode_d;
      led_q      <= led_d;
      paused_q   <= paused_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    speed_d    = speed_q;
    fwd_d      = fwd_q;
    en_d       = 1'b0;
    mode_d     = MODE_UPDATE;
    led_d      = led_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tick_c     = 1'b0;
    push_c     = 1'b0;
    pop_c      = 1'b0;

    case (state_q)
      ST_START: begin
        en_d    = 1'b1;
        mode_d  = MODE_RESET;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (tick_cnt_q == period_m1_c) begin
          tick_c     = 1'b1;
          tick_cnt_d = '0;
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
        if (evt_q[KEY_PAUSE]) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (evt_q[KEY_PAUSE]) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_START;
    endcase

    // Speed step overrides the counter after any coincident tick has fired
    if ((state_q != ST_START) && evt_q[KEY_SPEED]) begin
      speed_d    = (speed_q == LW'(SPEED_LEVELS - 1)) ? '0 : speed_q + LW'(1);
      tick_cnt_d = '0;
    end

    if (tick_c) begin
      en_d  = 1'b1;
      led_d = ~led_q;
      if (count_q != '0) begin
        pop_c    = 1'b1;
        fwd_d    = fifo_q[rd_ptr_q];
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
    end

    if ((state_q == ST_RUN) && dir_evt_c && (dir_cand_c[1] != ref_dir_c[1]) &&
        (count_q != CW'(DIR_FIFO_DEPTH))) begin
      push_c           = 1'b1;
      fifo_d[wr_ptr_q] = dir_cand_c;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    paused_d = (state_d == ST_PAUSE);
  end

  assign en        = en_q;
  assign mode      = mode_q;
  assign forward   = fwd_q;
  assign paused    = paused_q;
  assign speed_lvl = speed_q;
  assign led       = led_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed bench for snake_dir_ctrl: start pulse, debounce, turn queue, pause,
// speed levels and mid-run reset, with hand-computed expectations.
module tb_snake_dir_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_dir;
  logic       key_pause;
  logic       key_speed;
  logic       en;
  logic [3:0] mode;
  logic [1:0] forward;
  logic       paused;
  logic [1:0] speed_lvl;
  logic       led;

  int n_cmp = 0;
  int n_bad = 0;

  snake_dir_ctrl #(
    .TICK_BASE_CNT (64),
    .DEBOUNCE_CNT  (4),
    .KEY_ACTIVE_LOW(1'b1),
    .DIR_FIFO_DEPTH(2),
    .SPEED_LEVELS  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_key_dir  (key_dir),
    .i_key_pause(key_pause),
    .i_key_speed(key_speed),
    .en         (en),
    .mode       (mode),
    .forward    (forward),
    .paused     (paused),
    .speed_lvl  (speed_lvl),
    .led        (led)
  );

  always #5 clk = ~clk;

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Cycles until the next en strobe, bounded so a dead DUT cannot hang the run
  task automatic wait_en(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!en && n < 1000);
  endtask

  task automatic press_dir(input int idx, input int hold);
    key_dir[idx] = 1'b0;
    step(hold);
    key_dir[idx] = 1'b1;
  endtask

  int n;
  int en_seen;
  int exp_per[4] = '{32, 16, 8, 64};
  int exp_lvl[4] = '{1, 2, 3, 0};

  initial begin
    rst       = 1'b1;
    key_dir   = 4'hF;
    key_pause = 1'b1;
    key_speed = 1'b1;
    step(3);
    check_eq("rst_en", 32'(en), 0);
    check_eq("rst_mode", 32'(mode), 0);
    check_eq("rst_fwd", 32'(forward), 0);
    check_eq("rst_paused", 32'(paused), 0);
    check_eq("rst_speed", 32'(speed_lvl), 0);
    check_eq("rst_led", 32'(led), 0);

    // 1: start pulse, then ticks every 64 cycles
    rst = 1'b0;
    step(1);
    check_eq("start_en", 32'(en), 1);
    check_eq("start_mode", 32'(mode), 0);
    step(1);
    check_eq("post_start_en", 32'(en), 0);
    check_eq("post_start_mode", 32'(mode), 1);
    wait_en(n);
    check_eq("t1_first_tick", 32'(n + 1), 64);
    check_eq("t1_tick_mode", 32'(mode), 1);
    check_eq("t1_led1", 32'(led), 1);
    wait_en(n);
    check_eq("t1_period", 32'(n), 64);
    check_eq("t1_led0", 32'(led), 0);
    check_eq("t1_fwd", 32'(forward), 0);

    // 2: 3-cycle glitch ignored, 10-cycle press turns to Y_UP
    key_dir[2] = 1'b0;
    step(3);
    key_dir[2] = 1'b1;
    step(5);
    press_dir(2, 10);
    wait_en(n);
    check_eq("t2_period", 32'(n), 46);
    check_eq("t2_fwd_yup", 32'(forward), 2);
    press_dir(0, 8);
    wait_en(n);
    check_eq("t2b_period", 32'(n), 56);
    check_eq("t2b_fwd_xup", 32'(forward), 0);

    // 3: x_down rejected, y_down and x_up queued, y_up dropped on full queue
    press_dir(1, 8);
    press_dir(3, 8);
    press_dir(0, 8);
    press_dir(2, 8);
    wait_en(n);
    check_eq("t3_period", 32'(n), 32);
    check_eq("t3_fwd_ydown", 32'(forward), 3);
    wait_en(n);
    check_eq("t3_period2", 32'(n), 64);
    check_eq("t3_fwd_xup", 32'(forward), 0);
    wait_en(n);
    check_eq("t3_fwd_hold", 32'(forward), 0);

    // 4: turn arriving on the tick edge waits for the following tick
    step(57);
    key_dir[2] = 1'b0;
    step(7);
    check_eq("t4_tick_en", 32'(en), 1);
    check_eq("t4_fwd_same", 32'(forward), 0);
    step(3);
    key_dir[2] = 1'b1;
    wait_en(n);
    check_eq("t4_period", 32'(n), 61);
    check_eq("t4_fwd_next", 32'(forward), 2);

    // 5: pause at count 30, resume 34 cycles before the next tick
    step(23);
    key_pause = 1'b0;
    step(7);
    check_eq("t5_paused", 32'(paused), 1);
    step(1);
    key_pause = 1'b1;
    press_dir(0, 8);
    en_seen = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (en) en_seen++;
    end
    check_eq("t5_no_en", 32'(en_seen), 0);
    check_eq("t5_mode_paused", 32'(mode), 1);
    key_pause = 1'b0;
    step(7);
    check_eq("t5_unpaused", 32'(paused), 0);
    key_pause = 1'b1;
    wait_en(n);
    check_eq("t5_resume", 32'(n), 34);
    check_eq("t5_fwd", 32'(forward), 2);

    // 6: speed steps 32/16/8 then wrap to 64
    for (int s = 0; s < 4; s++) begin
      key_speed = 1'b0;
      step(7);
      check_eq("t6_lvl", 32'(speed_lvl), 32'(exp_lvl[s]));
      key_speed = 1'b1;
      wait_en(n);
      check_eq("t6_first", 32'(n), 32'(exp_per[s]));
      if (s < 3) begin
        wait_en(n);
        check_eq("t6_period", 32'(n), 32'(exp_per[s]));
      end
    end

    // Mid-run reset with two turns queued flushes the queue
    press_dir(0, 8);
    press_dir(3, 8);
    rst = 1'b1;
    step(1);
    check_eq("mr_fwd", 32'(forward), 0);
    check_eq("mr_en", 32'(en), 0);
    check_eq("mr_mode", 32'(mode), 0);
    rst = 1'b0;
    step(1);
    check_eq("mr_start_en", 32'(en), 1);
    check_eq("mr_start_mode", 32'(mode), 0);
    wait_en(n);
    check_eq("mr_period", 32'(n), 64);
    check_eq("mr_fwd1", 32'(forward), 0);
    wait_en(n);
    check_eq("mr_fwd2", 32'(forward), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
